// File: rtl/systolic_2x2_feeder.sv
// Initiator for the 2x2 systolic array: buffers A/B, feeds them with diagonal skew,
// waits for done (or timeout) and presents results on valid/ready. Optional SYS_FEEDER_PERF_EN.
module systolic_2x2_feeder #(
  parameter int DATA_W       = 32,
  parameter int RES_W        = 64,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [1:0]        in_idx,
  input  logic [DATA_W-1:0] in_data,
  input  logic              start,
  output logic              busy,
  output logic              arr_load,
  output logic [DATA_W-1:0] arr_row0,
  output logic [DATA_W-1:0] arr_row1,
  output logic [DATA_W-1:0] arr_col0,
  output logic [DATA_W-1:0] arr_col1,
  input  logic [RES_W-1:0]  arr_res00,
  input  logic [RES_W-1:0]  arr_res01,
  input  logic [RES_W-1:0]  arr_res10,
  input  logic [RES_W-1:0]  arr_res11,
  input  logic [3:0]        arr_carry,
  input  logic              arr_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_c00,
  output logic [RES_W-1:0]  out_c01,
  output logic [RES_W-1:0]  out_c10,
  output logic [RES_W-1:0]  out_c11,
  output logic [3:0]        out_carry,
  output logic              out_err
`ifdef SYS_FEEDER_PERF_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  localparam int CNT_W = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, FEED, WAIT, OUT} state_t;

  typedef struct packed {
    logic [RES_W-1:0] c00;
    logic [RES_W-1:0] c01;
    logic [RES_W-1:0] c10;
    logic [RES_W-1:0] c11;
    logic [3:0]       carry;
    logic             err;
  } res_t;

  state_t                   state, state_n;
  logic [1:0]               step, step_n;
  logic [CNT_W-1:0]         tcnt;
  logic [3:0][DATA_W-1:0]   a_q, b_q, a_n, b_n;
  logic                     tmo_hit;
  logic                     load_n;
  logic [DATA_W-1:0]        row0_n, row1_n, col0_n, col1_n;
  res_t                     res_q;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);
  assign tmo_hit   = (tcnt == CNT_W'(DONE_TIMEOUT - 1));

  assign out_c00   = res_q.c00;
  assign out_c01   = res_q.c01;
  assign out_c10   = res_q.c10;
  assign out_c11   = res_q.c11;
  assign out_carry = res_q.carry;
  assign out_err   = res_q.err;

  // Post-write matrix image, so a write in the start cycle is what k0 feeds.
  always_comb begin
    a_n = a_q;
    b_n = b_q;
    if (in_valid && state == IDLE) begin
      if (in_sel) b_n[in_idx] = in_data;
      else        a_n[in_idx] = in_data;
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    unique case (state)
      IDLE: if (start) begin
        state_n = FEED;
        step_n  = 2'd0;
      end
      FEED: begin
        if (step == 2'd2) state_n = WAIT;
        else              step_n  = step + 2'd1;
      end
      WAIT: if (arr_done || tmo_hit) state_n = OUT;
      OUT:  if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus values are chosen from the next step so the drive is registered.
  always_comb begin
    load_n = 1'b0;
    row0_n = '0;
    row1_n = '0;
    col0_n = '0;
    col1_n = '0;
    if (state_n == FEED) begin
      load_n = 1'b1;
      unique case (step_n)
        2'd0: begin
          row0_n = a_n[0];
          col0_n = b_n[0];
        end
        2'd1: begin
          row0_n = a_n[1];
          col0_n = b_n[2];
          row1_n = a_n[2];
          col1_n = b_n[1];
        end
        default: begin
          row1_n = a_n[3];
          col1_n = b_n[3];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      step     <= 2'd0;
      tcnt     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      arr_load <= 1'b0;
      arr_row0 <= '0;
      arr_row1 <= '0;
      arr_col0 <= '0;
      arr_col1 <= '0;
      res_q    <= '0;
    end else begin
      state    <= state_n;
      step     <= step_n;
      a_q      <= a_n;
      b_q      <= b_n;
      arr_load <= load_n;
      arr_row0 <= row0_n;
      arr_row1 <= row1_n;
      arr_col0 <= col0_n;
      arr_col1 <= col1_n;
      if (state == FEED)
        tcnt <= '0;
      else if (state == WAIT && !tmo_hit)
        tcnt <= tcnt + CNT_W'(1);
      // arr_done takes priority over a coincident timeout.
      if (state == WAIT && (arr_done || tmo_hit)) begin
        res_q.c00   <= arr_res00;
        res_q.c01   <= arr_res01;
        res_q.c10   <= arr_res10;
        res_q.c11   <= arr_res11;
        res_q.carry <= arr_carry;
        res_q.err   <= !arr_done;
      end
    end
  end

`ifdef SYS_FEEDER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)
      perf_cycles <= 16'd0;
    else if (state == IDLE && start)
      perf_cycles <= 16'd0;
    else if ((state == FEED || state == WAIT) && perf_cycles != 16'hFFFF)
      perf_cycles <= perf_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_2x2_feeder.sv
// Directed + randomized bench for systolic_2x2_feeder; the array is modelled by a
// matrix-product reference that drives the result bus.
module tb_systolic_2x2_feeder;
  localparam int DW = 32;
  localparam int RW = 64;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sel, start, busy;
  logic [1:0]    in_idx;
  logic [DW-1:0] in_data;
  logic          arr_load;
  logic [DW-1:0] arr_row0, arr_row1, arr_col0, arr_col1;
  logic [RW-1:0] arr_res00, arr_res01, arr_res10, arr_res11;
  logic [3:0]    arr_carry;
  logic          arr_done, out_valid, out_ready;
  logic [RW-1:0] out_c00, out_c01, out_c10, out_c11;
  logic [3:0]    out_carry;
  logic          out_err;
`ifdef SYS_FEEDER_PERF_EN
  logic [15:0]   perf_cycles;
`endif

  always #5 clk = ~clk;

  systolic_2x2_feeder #(.DATA_W(DW), .RES_W(RW), .DONE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_idx(in_idx),
    .in_data(in_data), .start(start), .busy(busy),
    .arr_load(arr_load), .arr_row0(arr_row0), .arr_row1(arr_row1),
    .arr_col0(arr_col0), .arr_col1(arr_col1),
    .arr_res00(arr_res00), .arr_res01(arr_res01), .arr_res10(arr_res10), .arr_res11(arr_res11),
    .arr_carry(arr_carry), .arr_done(arr_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c00(out_c00), .out_c01(out_c01), .out_c10(out_c10), .out_c11(out_c11),
    .out_carry(out_carry), .out_err(out_err)
`ifdef SYS_FEEDER_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference copy of the matrices, index = row*2+col.
  logic [DW-1:0] ma[4];
  logic [DW-1:0] mb[4];
  logic [RW-1:0] ex_res[4];
  logic [3:0]    ex_carry;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // C = A*B with the 65th bit of each dot product as the carry.
  task automatic model_product();
    logic [64:0] s;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 65'(ma[i*2]) * 65'(mb[j]) + 65'(ma[i*2+1]) * 65'(mb[2+j]);
        ex_res[i*2+j]   = s[63:0];
        ex_carry[i*2+j] = s[64];
      end
  endtask

  task automatic write_el(input bit sel, input int idx, input logic [DW-1:0] d);
    in_valid = 1'b1; in_sel = sel; in_idx = 2'(idx); in_data = d;
    tick();
    in_valid = 1'b0;
    if (sel) mb[idx] = d; else ma[idx] = d;
  endtask

  task automatic set_arr(input logic [RW-1:0] r0, r1, r2, r3, input logic [3:0] c);
    arr_res00 = r0; arr_res01 = r1; arr_res10 = r2; arr_res11 = r3; arr_carry = c;
  endtask

  // dly < 0: array never answers (timeout). widx 0..3 -> A, 4..7 -> B.
  task automatic run(input int dly, input int hold, input bit noise,
                     input bit wr, input int widx, input logic [DW-1:0] wd);
    logic [DW-1:0] r0[3], r1[3], c0[3], c1[3];
    logic [RW-1:0] dx[4];
    logic [3:0]    dc;
    logic          err_exp;
    int            waited;
    if (wr) begin
      in_valid = 1'b1; in_sel = (widx >= 4); in_idx = 2'(widx % 4); in_data = wd;
      if (widx >= 4) mb[widx-4] = wd; else ma[widx] = wd;
    end
    r0 = '{ma[0], ma[1], '0};
    c0 = '{mb[0], mb[2], '0};
    r1 = '{'0, ma[2], ma[3]};
    c1 = '{'0, mb[1], mb[3]};
    start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("feed_load", 64'(arr_load), 64'd1);
      chk("feed_row0", 64'(arr_row0), 64'(r0[k]));
      chk("feed_col0", 64'(arr_col0), 64'(c0[k]));
      chk("feed_row1", 64'(arr_row1), 64'(r1[k]));
      chk("feed_col1", 64'(arr_col1), 64'(c1[k]));
      chk("feed_busy", 64'({busy, in_ready, out_valid}), 64'b100);
      if (noise) begin start = 1'b1; arr_done = 1'b1; end
      tick();
    end
    start = 1'b0; arr_done = 1'b0;
    chk("wait_load", 64'(arr_load), 64'd0);
    chk("wait_rows", {arr_row0, arr_row1}, 64'd0);
    chk("wait_cols", {arr_col0, arr_col1}, 64'd0);
    if (dly >= 0) begin
      model_product();
      dx = ex_res; dc = ex_carry; err_exp = 1'b0; waited = dly;
    end else begin
      for (int i = 0; i < 4; i++) dx[i] = {$urandom, $urandom};
      dc = 4'($urandom); err_exp = 1'b1; waited = TO - 1;
    end
    set_arr(dx[0], dx[1], dx[2], dx[3], dc);
    for (int i = 0; i < waited; i++) tick();
    chk("wait_no_out", 64'(out_valid), 64'd0);
    if (dly >= 0) arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("out_c00", out_c00, dx[0]);
    chk("out_c01", out_c01, dx[1]);
    chk("out_c10", out_c10, dx[2]);
    chk("out_c11", out_c11, dx[3]);
    chk("out_carry", 64'(out_carry), 64'(dc));
    chk("out_err", 64'(out_err), 64'(err_exp));
`ifdef SYS_FEEDER_PERF_EN
    chk("perf", 64'(perf_cycles), 64'(3 + waited + 1));
`endif
    // Scramble array side, try a write and a stray done while the result is held.
    set_arr({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, ~dc);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_sel = 1'b0; in_idx = 2'd0; in_data = 32'hDEAD_BEEF;
      arr_done = 1'b1;
      tick();
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_c00", out_c00, dx[0]);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; arr_done = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs", 64'({out_valid, in_ready, busy}), 64'b010);
    chk("retain_c11", out_c11, dx[3]);
    chk("retain_err", 64'(out_err), 64'(err_exp));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_idx = 2'd0; in_data = '0;
    start = 1'b0; arr_done = 1'b0; out_ready = 1'b0;
    set_arr('0, '0, '0, '0, 4'd0);
    for (int i = 0; i < 4; i++) begin ma[i] = '0; mb[i] = '0; end
    tick(); tick();
    chk("rst_flags", 64'({in_ready, busy, out_valid, arr_load, out_err}), 64'b10000);
    chk("rst_c00", out_c00, 64'd0);
    chk("rst_carry", 64'(out_carry), 64'd0);
    rst = 1'b0;
    tick();

    // Reference example, held 10 cycles before the handshake.
    for (int i = 0; i < 4; i++) write_el(1'b0, i, DW'(i + 1));
    for (int i = 0; i < 4; i++) write_el(1'b1, i, DW'(i + 5));
    run(5, 10, 1'b0, 1'b0, 0, '0);
    chk("ex_c00", out_c00, 64'd19);
    chk("ex_c01", out_c01, 64'd22);
    chk("ex_c10", out_c10, 64'd43);
    chk("ex_c11", out_c11, 64'd50);
    chk("ex_carry", 64'(out_carry), 64'd0);

    // Timeout, then a normal run, then done coinciding with the timeout.
    run(-1, 1, 1'b0, 1'b0, 0, '0);
    run(2, 0, 1'b0, 1'b0, 0, '0);
    run(TO - 1, 0, 1'b0, 1'b0, 0, '0);

    // Write in the start cycle is fed.
    run(4, 1, 1'b1, 1'b1, 0, 32'd9);
    chk("wr_start_c00", out_c00, 64'd59);

    // Reset during FEED k1.
    start = 1'b1; tick(); start = 1'b0; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_flags", 64'({arr_load, busy, in_ready, out_valid, out_err}), 64'b00100);
    chk("midrst_rows", {arr_row0, arr_row1}, 64'd0);
    chk("midrst_cols", {arr_col0, arr_col1}, 64'd0);
    chk("midrst_c00", out_c00, 64'd0);
    for (int i = 0; i < 4; i++) begin ma[i] = '0; mb[i] = '0; end
    run(3, 0, 1'b0, 1'b0, 0, '0);

    // Randomized runs.
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 3) != 0) write_el(i >= 4, i % 4, $urandom);
      run(int'($urandom_range(0, 10)), int'($urandom_range(0, 3)), 1'($urandom),
          1'($urandom), int'($urandom_range(0, 7)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
